dcache1_puke_sched: RTL and testbench
=====================================

DCACHE1_PUKE_SCHED -- requirements
Module: dcache1_puke_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, invalidate queue entries; a power of 2, at least 8.
REQ-002 SHALL have port clk  in  1  clock; all state updates on negedge clk.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_en  in  4  per-requester invalidate request valid.
REQ-005 SHALL have ports req_addr0..req_addr3  in  7 each  set index; bit 6 selects odd bank, bits 5:0 the set.
REQ-006 SHALL have port req_ready  out  1  all four requests accepted this edge.
REQ-007 SHALL have port flush_req  in  1  request a full-cache invalidate walk.
REQ-008 SHALL have port flush_busy  out  1  flush FSM not in IDLE.
REQ-009 SHALL have port flush_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port stall  in  1  tag array busy; suppresses issue.
REQ-011 SHALL have port puke_en  out  6  per-slot invalidate strobe, registered.
REQ-012 SHALL have port puke_addr  out  42  slot i at bits 7i+6:7i, registered.
REQ-013 SHALL have port q_count  out  log2(DEPTH)+1  current queue occupancy.

Function
REQ-014 SHALL drive req_ready = (state==IDLE) && (DEPTH-q_count >= 4) && ~flush_req, combinational from registered state.
REQ-015 SHALL enqueue, when req_ready, every asserted req_en[j] in ascending j order into consecutive FIFO slots at the same edge; unasserted requesters consume no slot.
REQ-016 SHALL ignore req_en when req_ready=0; requesters hold and retry.
REQ-017 SHALL, at each edge with stall=0 in IDLE or DRAIN, pop n=min(q_count,6) oldest entries into puke slots 0..n-1 in FIFO order, setting puke_en[i]=1 for i<n and 0 otherwise.
REQ-018 SHALL, at an edge with stall=1, clear puke_en to 0, pop nothing and hold puke_addr.
REQ-019 SHALL compute pop from pre-edge occupancy; entries pushed at edge k are eligible for pop at edge k+1 at the earliest (puke_en visible after edge k+1).
REQ-020 SHALL update q_count = q_count + pushed - popped at each edge; wrap the read and write pointers modulo DEPTH.
REQ-021 SHALL never overflow; with DEPTH=8, push and pop in the same edge are both permitted.
REQ-022 SHALL implement flush FSM states IDLE, DRAIN, WALK, DONE.
REQ-023 SHALL move IDLE->DRAIN on flush_req=1; queue pushes are blocked from that edge.
REQ-024 SHALL move DRAIN->WALK when q_count=0 and puke_en is not being loaded with queue entries; walk counter set to 0.
REQ-025 SHALL, in WALK with stall=0, issue indices counter..counter+5 (each capped at 127) on slots 0..5 and advance counter by 6.
REQ-026 SHALL issue 21 full cycles plus one cycle of 2 slots (126, 127) in WALK, 22 issue edges in total, then move to DONE.
REQ-027 SHALL freeze the walk counter and clear puke_en while stall=1 in WALK.
REQ-028 SHALL pulse flush_done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL ignore a flush_req asserted while flush_busy=1; it does not queue a second flush.

Reset
REQ-030 SHALL, on rst, set q_count=0, pointers=0, state=IDLE, walk counter=0, puke_en=0, puke_addr=0, flush_done=0, flush_busy=0; req_ready=1 in the following cycle.
REQ-031 SHALL abort any in-progress flush or queue contents on rst without issuing further strobes.

Configuration
REQ-032 SHALL, with DCACHE1_PUKE_DEDUP_EN defined, drop (accept but not enqueue) any request whose 7-bit address equals a valid queued entry or a lower-indexed same-cycle request; req_ready is unaffected.
REQ-033 SHALL, without DCACHE1_PUKE_DEDUP_EN, enqueue every accepted request, duplicates included.

Verification
REQ-034 Bench SHALL cover single request: req_en=0001, addr0=0x45 -> next edge puke_en=000001, puke_addr[6:0]=0x45, q_count returns to 0.
REQ-035 Bench SHALL cover burst: 4 requests on each of 2 consecutive edges (8 entries) -> one edge with 6 slots in FIFO order, then one edge with 2; req_ready=0 while q_count>4.
REQ-036 Bench SHALL cover stall: stall=1 for 3 cycles with 5 queued -> puke_en=0 and q_count=5 for 3 cycles, then all 5 issued on the first unstalled edge.
REQ-037 Bench SHALL cover flush: flush_req with 3 queued and stall=0 -> those 3 issued first, then 22 WALK issues covering 0..127 exactly once, then flush_done pulsed once.
REQ-038 Bench SHALL cover dedup: with DCACHE1_PUKE_DEDUP_EN, req_en=1111 with all addresses 0x10 -> exactly one slot issued; without the macro, four slots issued.
REQ-039 Bench SHALL cover reset mid-WALK: rst at counter=42 -> next cycle state=IDLE, puke_en=0, no flush_done pulse.

Source files
------------

// File: rtl/dcache1_puke_sched_if.sv
// Invalidate-scheduler bus: requester inputs, flush control and puke strobe outputs.
// The scheduler is the slave; the requester/controller side is the master.
interface dcache1_puke_sched_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    req_en;
    logic [6:0]    req_addr0;
    logic [6:0]    req_addr1;
    logic [6:0]    req_addr2;
    logic [6:0]    req_addr3;
    logic          req_ready;
    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;
    logic          stall;
    logic [5:0]    puke_en;
    logic [41:0]   puke_addr;
    logic [CW-1:0] q_count;

    modport master (
        output req_en, req_addr0, req_addr1, req_addr2, req_addr3, flush_req, stall,
        input  req_ready, flush_busy, flush_done, puke_en, puke_addr, q_count
    );

    modport slave (
        input  req_en, req_addr0, req_addr1, req_addr2, req_addr3, flush_req, stall,
        output req_ready, flush_busy, flush_done, puke_en, puke_addr, q_count
    );
endinterface

// File: rtl/dcache1_puke_sched.sv
// D-cache invalidate ("puke") scheduler: 4-wide request FIFO drained 6 per edge, plus a full-cache flush walk.
// Optional DCACHE1_PUKE_DEDUP_EN drops requests whose set index is already queued or requested earlier this edge.
module dcache1_puke_sched #(
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    dcache1_puke_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // state | meaning
    // IDLE  | normal queue operation, pushes allowed
    // DRAIN | flush requested, emptying queue, pushes blocked
    // WALK  | issuing every set index 0..127, six per edge
    // DONE  | one-cycle flush_done pulse
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, WALK = 2'd2, DONE = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [6:0]    mem_q [DEPTH];
    logic [6:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    walk_q, walk_d;
    logic [5:0]    puke_en_q, puke_en_d;
    logic [41:0]   puke_addr_q, puke_addr_d;
    logic          ready;
    logic [6:0]    req_addr [4];

    assign req_addr[0] = bus.req_addr0;
    assign req_addr[1] = bus.req_addr1;
    assign req_addr[2] = bus.req_addr2;
    assign req_addr[3] = bus.req_addr3;

    // All state moves on the falling edge of clk.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            walk_q      <= '0;
            puke_en_q   <= '0;
            puke_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            walk_q      <= walk_d;
            puke_en_q   <= puke_en_d;
            puke_addr_q <= puke_addr_d;
        end
    end

    always_comb begin
        logic [2:0] n_pop;
        logic [2:0] n_push;
        logic [7:0] idx;
        logic       dup;
`ifdef DCACHE1_PUKE_DEDUP_EN
        logic [PW-1:0] off;
        off = '0;
`endif
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        walk_d      = walk_q;
        puke_en_d   = puke_en_q;
        puke_addr_d = puke_addr_q;
        n_pop       = '0;
        n_push      = '0;
        idx         = '0;
        dup         = 1'b0;

        case (state_q)
            IDLE, DRAIN: begin
                if (bus.stall) begin
                    puke_en_d = '0;
                end else begin
                    n_pop     = (count_q >= CW'(6)) ? 3'd6 : 3'(count_q);
                    puke_en_d = '0;
                    for (int i = 0; i < 6; i++) begin
                        if (3'(i) < n_pop) begin
                            puke_en_d[i]          = 1'b1;
                            puke_addr_d[7*i +: 7] = mem_q[rd_ptr_q + PW'(i)];
                        end
                    end
                end
                if (state_q == IDLE && bus.flush_req) state_d = DRAIN;
                if (state_q == DRAIN && count_q == '0) begin
                    state_d = WALK;
                    walk_d  = '0;
                end
            end
            WALK: begin
                puke_en_d = '0;
                if (!bus.stall) begin
                    // Slots past index 127 on the final edge stay idle.
                    for (int i = 0; i < 6; i++) begin
                        idx = walk_q + 8'(i);
                        if (idx <= 8'd127) begin
                            puke_en_d[i]          = 1'b1;
                            puke_addr_d[7*i +: 7] = idx[6:0];
                        end
                    end
                    walk_d = walk_q + 8'd6;
                    if (walk_q >= 8'd126) state_d = DONE;
                end
            end
            default: begin
                puke_en_d = '0;
                state_d   = IDLE;
            end
        endcase

        if (ready) begin
            for (int j = 0; j < 4; j++) begin
                if (bus.req_en[j]) begin
                    dup = 1'b0;
`ifdef DCACHE1_PUKE_DEDUP_EN
                    for (int k = 0; k < DEPTH; k++) begin
                        off = PW'(k) - rd_ptr_q;
                        if (({1'b0, off} < count_q) && (mem_q[k] == req_addr[j])) dup = 1'b1;
                    end
                    for (int l = 0; l < j; l++) begin
                        if (bus.req_en[l] && (req_addr[l] == req_addr[j])) dup = 1'b1;
                    end
`endif
                    if (!dup) begin
                        mem_d[wr_ptr_q + PW'(n_push)] = req_addr[j];
                        n_push = n_push + 3'd1;
                    end
                end
            end
        end

        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        count_d  = count_q + CW'(n_push) - CW'(n_pop);
    end

    always_comb begin
        ready          = (state_q == IDLE) && (count_q <= CW'(DEPTH - 4)) && !bus.flush_req;
        bus.req_ready  = ready;
        bus.flush_busy = (state_q != IDLE);
        bus.flush_done = (state_q == DONE);
        bus.puke_en    = puke_en_q;
        bus.puke_addr  = puke_addr_q;
        bus.q_count    = count_q;
    end
endmodule

// File: tb/tb_dcache1_puke_sched.sv
// Bench for dcache1_puke_sched: queue/flush reference model checked every cycle plus directed literal checks.
// Build with +define+DCACHE1_PUKE_DEDUP_EN to exercise the dedup configuration.
module tb_dcache1_puke_sched;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   started = 0;

    dcache1_puke_sched_if #(.DEPTH(DEPTH)) bus ();
    dcache1_puke_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] raddr(input int j);
        case (j)
            0: return bus.req_addr0;
            1: return bus.req_addr1;
            2: return bus.req_addr2;
            default: return bus.req_addr3;
        endcase
    endfunction

    // Reference model: queue of pending set indices, flush phase and next walk index.
    int         mq[$];
    int         pre_q[$];
    int         seen_q[$];
    int         mode;      // 0 idle, 1 drain, 2 walk, 3 done
    int         walk;
    logic [5:0] m_en;
    logic [41:0] m_addr;
    int         pre_n, nm, npop;
    bit         rdy, dup;
    logic [6:0] a;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mode   = 0;
            walk   = 0;
            m_en   = '0;
            m_addr = '0;
        end else begin
            pre_q = mq;
            pre_n = mq.size();
            rdy   = (mode == 0) && (DEPTH - pre_n >= 4) && !bus.flush_req;
            nm    = mode;
            if (mode == 0 || mode == 1) begin
                if (bus.stall) m_en = '0;
                else begin
                    npop = (pre_n < 6) ? pre_n : 6;
                    m_en = '0;
                    for (int i = 0; i < npop; i++) begin
                        m_en[i] = 1'b1;
                        m_addr[7*i +: 7] = 7'(mq.pop_front());
                    end
                end
                if (mode == 0 && bus.flush_req) nm = 1;
                if (mode == 1 && pre_n == 0) begin nm = 2; walk = 0; end
            end else if (mode == 2) begin
                m_en = '0;
                if (!bus.stall) begin
                    for (int i = 0; i < 6; i++) begin
                        if (walk + i <= 127) begin
                            m_en[i] = 1'b1;
                            m_addr[7*i +: 7] = 7'(walk + i);
                        end
                    end
                    walk += 6;
                    if (walk > 127) nm = 3;
                end
            end else begin
                m_en = '0;
                nm   = 0;
            end
            if (rdy) begin
                seen_q.delete();
                for (int j = 0; j < 4; j++) begin
                    if (bus.req_en[j]) begin
                        a   = raddr(j);
                        dup = 0;
`ifdef DCACHE1_PUKE_DEDUP_EN
                        foreach (pre_q[k]) if (pre_q[k] == int'(a)) dup = 1;
                        foreach (seen_q[k]) if (seen_q[k] == int'(a)) dup = 1;
`endif
                        seen_q.push_back(int'(a));
                        if (!dup) mq.push_back(int'(a));
                    end
                end
            end
            mode = nm;
        end
    end

    always @(posedge clk) begin
        #2;
        if (started) begin
            check("q_count", bus.q_count, mq.size());
            check("req_ready", bus.req_ready,
                  (mode == 0) && (DEPTH - mq.size() >= 4) && !bus.flush_req);
            check("flush_busy", bus.flush_busy, mode != 0);
            check("flush_done", bus.flush_done, mode == 3);
            check("puke_en", bus.puke_en, m_en);
            for (int i = 0; i < 6; i++)
                if (m_en[i]) check("puke_addr_slot", bus.puke_addr[7*i +: 7], m_addr[7*i +: 7]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] en, input logic [6:0] a0, input logic [6:0] a1,
                           input logic [6:0] a2, input logic [6:0] a3);
        bus.req_en    = en;
        bus.req_addr0 = a0;
        bus.req_addr1 = a1;
        bus.req_addr2 = a2;
        bus.req_addr3 = a3;
    endtask

    int  hits[128];
    int  walk_edges, done_pulses, badidx;
    bit  fin, seen_done;

    initial begin
        rst = 1'b1;
        bus.flush_req = 1'b0;
        bus.stall     = 1'b0;
        set_req(4'b0000, 7'h0, 7'h0, 7'h0, 7'h0);
        tick();
        tick();
        started = 1;
        rst = 1'b0;
        check("rst_q_count", bus.q_count, 0);
        check("rst_puke_en", bus.puke_en, 0);
        check("rst_puke_addr", bus.puke_addr, 0);
        check("rst_busy", bus.flush_busy, 0);
        check("rst_ready", bus.req_ready, 1);

        // single request
        set_req(4'b0001, 7'h45, 7'h0, 7'h0, 7'h0);
        tick();
        set_req(4'b0000, 7'h0, 7'h0, 7'h0, 7'h0);
        check("single_queued", bus.q_count, 1);
        check("single_no_early_issue", bus.puke_en, 0);
        tick();
        check("single_en", bus.puke_en, 6'b000001);
        check("single_addr", bus.puke_addr[6:0], 7'h45);
        check("single_q_count", bus.q_count, 0);
        tick();

        // burst of 8 held back by stall, then one retry while full
        bus.stall = 1'b1;
        set_req(4'b1111, 7'h01, 7'h02, 7'h03, 7'h04);
        tick();
        set_req(4'b1111, 7'h05, 7'h06, 7'h07, 7'h08);
        tick();
        check("burst_count8", bus.q_count, 8);
        check("burst_ready_low", bus.req_ready, 0);
        set_req(4'b1111, 7'h7f, 7'h7e, 7'h7d, 7'h7c);
        tick();
        check("burst_retry_ignored", bus.q_count, 8);
        set_req(4'b0000, 7'h0, 7'h0, 7'h0, 7'h0);
        bus.stall = 1'b0;
        tick();
        check("burst_en6", bus.puke_en, 6'b111111);
        for (int i = 0; i < 6; i++) check("burst_order6", bus.puke_addr[7*i +: 7], 7'(i + 1));
        check("burst_count2", bus.q_count, 2);
        tick();
        check("burst_en2", bus.puke_en, 6'b000011);
        check("burst_addr7", bus.puke_addr[6:0], 7'h07);
        check("burst_addr8", bus.puke_addr[13:7], 7'h08);
        check("burst_empty", bus.q_count, 0);

        // stall with 5 queued
        bus.stall = 1'b1;
        set_req(4'b1111, 7'h30, 7'h31, 7'h32, 7'h33);
        tick();
        set_req(4'b0001, 7'h34, 7'h0, 7'h0, 7'h0);
        tick();
        set_req(4'b0000, 7'h0, 7'h0, 7'h0, 7'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_en", bus.puke_en, 0);
            check("stall_count", bus.q_count, 5);
        end
        bus.stall = 1'b0;
        tick();
        check("stall_release_en", bus.puke_en, 6'b011111);
        check("stall_release_slot4", bus.puke_addr[34:28], 7'h34);
        check("stall_release_count", bus.q_count, 0);
        tick();

        // dedup
        set_req(4'b1111, 7'h10, 7'h10, 7'h10, 7'h10);
        tick();
        set_req(4'b0000, 7'h0, 7'h0, 7'h0, 7'h0);
        tick();
`ifdef DCACHE1_PUKE_DEDUP_EN
        check("dedup_en", bus.puke_en, 6'b000001);
`else
        check("dup_en", bus.puke_en, 6'b001111);
`endif
        check("dup_slot0", bus.puke_addr[6:0], 7'h10);
        tick();

        // flush with 3 queued
        bus.stall = 1'b1;
        set_req(4'b0111, 7'h21, 7'h22, 7'h23, 7'h0);
        tick();
        set_req(4'b0000, 7'h0, 7'h0, 7'h0, 7'h0);
        bus.stall     = 1'b0;
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        check("flush_drain_en", bus.puke_en, 6'b000111);
        check("flush_drain_a0", bus.puke_addr[6:0], 7'h21);
        check("flush_drain_a2", bus.puke_addr[20:14], 7'h23);
        check("flush_busy_set", bus.flush_busy, 1);
        foreach (hits[k]) hits[k] = 0;
        walk_edges = 0; done_pulses = 0; fin = 0; seen_done = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            tick();
            if (bus.puke_en != 0) begin
                walk_edges++;
                for (int i = 0; i < 6; i++)
                    if (bus.puke_en[i]) hits[bus.puke_addr[7*i +: 7]]++;
            end
            if (bus.flush_done) begin done_pulses++; seen_done = 1; end
            if (seen_done && !bus.flush_busy) fin = 1;
        end
        check("flush_finished", fin, 1);
        check("walk_edges", walk_edges, 22);
        check("done_pulses", done_pulses, 1);
        badidx = 0;
        foreach (hits[k]) if (hits[k] != 1) badidx++;
        check("walk_cover_once", badidx, 0);
        tick();

        // reset in the middle of WALK at counter 42
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        tick();
        for (int c = 0; c < 7; c++) tick();
        check("midwalk_slot0", bus.puke_addr[6:0], 7'd36);
        check("midwalk_en", bus.puke_en, 6'b111111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midwalk_rst_busy", bus.flush_busy, 0);
        check("midwalk_rst_en", bus.puke_en, 0);
        check("midwalk_rst_done", bus.flush_done, 0);
        check("midwalk_rst_ready", bus.req_ready, 1);
        done_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.flush_done || bus.puke_en != 0) done_pulses++;
        end
        check("midwalk_quiet", done_pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
